// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - host-to-device PS/2 command transmitter
//
// Ports:
//   inclock        system clock, all state updates on its rising edge
//   resetn         asynchronous active-low reset
//   send_command   one-cycle request to transmit command_byte (ignored while busy)
//   command_byte   byte to transmit, captured when the request is accepted
//   ps2_clock_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in    raw PS/2 data line (asynchronous)
//   ps2_clock_oe   1 pulls the PS/2 clock line low, 0 releases it
//   ps2_data_oe    1 pulls the PS/2 data line low, 0 releases it
//   busy           high while a frame is in progress
//   command_sent   one-cycle pulse when the device acknowledged the frame
//   tx_error       one-cycle pulse on any failure
//   error_code     last failure: 00 none, 01 start timeout, 10 bit timeout, 11 no ack

module ps2_command_tx #(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic       send_command,
    input  logic [7:0] command_byte,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       command_sent,
    output logic       tx_error,
    output logic [1:0] error_code
);

    // One shared timer serves the inhibit delay and both timeouts, so it is
    // sized for whichever of the three limits is largest.
    localparam int MAX_A      = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                        : START_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > BIT_TIMEOUT_CYCLES) ? MAX_A : BIT_TIMEOUT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BIT_LIMIT    = TW'(BIT_TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_BIT   = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        WAIT_FIRST,
        SHIFT,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    edge_cnt;
    logic [7:0]    tx_byte;
    logic          parity;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;

    // Falling edge of the synchronized device clock: high last cycle, low now.
    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            timer        <= '0;
            edge_cnt     <= '0;
            tx_byte      <= '0;
            parity       <= 1'b0;
            clk_meta     <= 1'b1;
            clk_sync     <= 1'b1;
            clk_prev     <= 1'b1;
            data_meta    <= 1'b1;
            data_sync    <= 1'b1;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            busy         <= 1'b0;
            command_sent <= 1'b0;
            tx_error     <= 1'b0;
            error_code   <= ERR_NONE;
        end else begin
            clk_meta  <= ps2_clock_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;

            command_sent <= 1'b0;
            tx_error     <= 1'b0;
            timer        <= timer + 1'b1;

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (send_command) begin
                        tx_byte      <= command_byte;
                        parity       <= ~^command_byte;
                        error_code   <= ERR_NONE;
                        edge_cnt     <= '0;
                        state        <= INHIBIT;
                        busy         <= 1'b1;
                        ps2_clock_oe <= 1'b1;
                        ps2_data_oe  <= 1'b0;
                    end
                end

                INHIBIT: begin
                    if (timer == INHIBIT_LAST) begin
                        timer       <= '0;
                        state       <= START;
                        ps2_data_oe <= 1'b1;
                    end
                end

                // Data is already low; releasing the clock hands control to the device.
                START: begin
                    timer        <= '0;
                    state        <= WAIT_FIRST;
                    ps2_clock_oe <= 1'b0;
                end

                WAIT_FIRST: begin
                    if (fall) begin
                        timer       <= '0;
                        edge_cnt    <= 4'd1;
                        state       <= SHIFT;
                        ps2_data_oe <= ~tx_byte[0];
                    end else if (timer == START_LAST) begin
                        timer        <= '0;
                        edge_cnt     <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        tx_error     <= 1'b1;
                        error_code   <= ERR_START;
                    end
                end

                // edge_cnt holds the number of edges seen so far; the edge
                // arriving now is edge_cnt+1 and selects the next line level.
                SHIFT: begin
                    if (fall) begin
                        timer    <= '0;
                        edge_cnt <= edge_cnt + 4'd1;
                        case (edge_cnt)
                            4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7: ps2_data_oe <= ~tx_byte[edge_cnt[2:0]];
                            4'd8:             ps2_data_oe <= ~parity;
                            4'd9: begin
                                ps2_data_oe <= 1'b0;
                                state       <= WAIT_ACK;
                            end
                            default:          ps2_data_oe <= ps2_data_oe;
                        endcase
                    end else if (timer == BIT_LIMIT) begin
                        timer        <= '0;
                        edge_cnt     <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        tx_error     <= 1'b1;
                        error_code   <= ERR_BIT;
                    end
                end

                WAIT_ACK: begin
                    if (fall) begin
                        timer    <= '0;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (!data_sync) begin
                            state <= WAIT_IDLE;
                        end else begin
                            edge_cnt     <= '0;
                            state        <= IDLE;
                            busy         <= 1'b0;
                            ps2_clock_oe <= 1'b0;
                            ps2_data_oe  <= 1'b0;
                            tx_error     <= 1'b1;
                            error_code   <= ERR_NOACK;
                        end
                    end else if (timer == BIT_LIMIT) begin
                        timer        <= '0;
                        edge_cnt     <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                        ps2_clock_oe <= 1'b0;
                        ps2_data_oe  <= 1'b0;
                        tx_error     <= 1'b1;
                        error_code   <= ERR_BIT;
                    end
                end

                // The frame only counts as delivered once the device has
                // released both lines after its acknowledge.
                WAIT_IDLE: begin
                    timer <= '0;
                    if (clk_sync && data_sync) begin
                        edge_cnt     <= '0;
                        state        <= IDLE;
                        busy         <= 1'b0;
                        command_sent <= 1'b1;
                    end
                end

                default: begin
                    timer        <= '0;
                    edge_cnt     <= '0;
                    state        <= IDLE;
                    busy         <= 1'b0;
                    ps2_clock_oe <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb/tb_ps2_command_tx.sv - self-checking bench for ps2_command_tx with a PS/2 device model

module tb_ps2_command_tx;

    logic       inclock = 1'b0;
    logic       resetn;
    logic       send_command;
    logic [7:0] command_byte;
    logic       ps2_clock_in;
    logic       ps2_data_in;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       command_sent;
    logic       tx_error;
    logic [1:0] error_code;

    logic dev_clk;
    logic dev_data;

    int checks = 0;
    int errors = 0;
    int sent_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_command_tx #(
        .INHIBIT_CYCLES      (10),
        .START_TIMEOUT_CYCLES(200),
        .BIT_TIMEOUT_CYCLES  (50)
    ) dut (
        .inclock     (inclock),
        .resetn      (resetn),
        .send_command(send_command),
        .command_byte(command_byte),
        .ps2_clock_in(ps2_clock_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .command_sent(command_sent),
        .tx_error    (tx_error),
        .error_code  (error_code)
    );

    always #5 inclock = ~inclock;

    // Open-drain wired-AND of host and device on each line.
    assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
    assign ps2_data_in  = dev_data & ~ps2_data_oe;

    always @(negedge inclock) begin
        if (command_sent) sent_cnt++;
        if (tx_error) err_cnt++;
        if (command_sent && tx_error) both_cnt++;
    end

    // Line level the host must drive after falling edge n of a frame.
    function automatic logic expected_oe(input logic [7:0] b, input int n);
        logic odd_parity;
        odd_parity = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        if (n <= 8) return ~b[n-1];
        if (n == 9) return ~odd_parity;
        return 1'b0;
    endfunction

    task automatic start_send(input logic [7:0] b);
        @(negedge inclock);
        send_command = 1'b1;
        command_byte = b;
        @(negedge inclock);
        send_command = 1'b0;
        command_byte = $urandom;
    endtask

    // Device model: waits for the host request-to-send, then clocks `edges`
    // falling edges, recording the host data level after edges 1..10 and
    // presenting ack_bit on the data line before edge 11.
    task automatic run_device(input int edges, input logic ack_bit,
                              output logic [10:1] seen, output bit ok);
        seen = '0;
        ok   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge inclock);
            if (busy && !ps2_clock_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        repeat (5) @(negedge inclock);
        for (int n = 1; n <= edges; n++) begin
            if (n == 11) dev_data = ack_bit;
            repeat (2) @(negedge inclock);
            dev_clk = 1'b0;
            repeat (8) @(negedge inclock);
            if (n <= 10) seen[n] = ps2_data_oe;
            dev_clk = 1'b1;
            repeat (8) @(negedge inclock);
        end
        dev_data = 1'b1;
        dev_clk  = 1'b1;
    endtask

    task automatic wait_done(input int s0, input int e0);
        for (int i = 0; i < 300; i++) begin
            @(negedge inclock);
            if (sent_cnt != s0 || err_cnt != e0) break;
        end
        repeat (5) @(negedge inclock);
    endtask

    task automatic test_reset;
        resetn       = 1'b0;
        send_command = 1'b0;
        command_byte = 8'h00;
        dev_clk      = 1'b1;
        dev_data     = 1'b1;
        repeat (3) @(negedge inclock);
        checks++; if (ps2_clock_oe !== 1'b0) begin errors++; $display("FAIL reset_clock_oe got %b want 0", ps2_clock_oe); end
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (command_sent !== 1'b0) begin errors++; $display("FAIL reset_command_sent got %b want 0", command_sent); end
        checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL reset_tx_error got %b want 0", tx_error); end
        checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL reset_error_code got %b want 00", error_code); end
        resetn = 1'b1;
        repeat (3) @(negedge inclock);
    endtask

    task automatic test_send(input logic [7:0] b);
        logic [10:1] seen;
        bit ok;
        int s0, e0;
        s0 = sent_cnt;
        e0 = err_cnt;
        start_send(b);
        run_device(11, 1'b0, seen, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL send_%h_request got %b want 1", b, ok); end
        for (int n = 1; n <= 10; n++) begin
            checks++;
            if (seen[n] !== expected_oe(b, n)) begin
                errors++;
                $display("FAIL send_%h_edge%0d data_oe got %b want %b", b, n, seen[n], expected_oe(b, n));
            end
        end
        wait_done(s0, e0);
        checks++; if (sent_cnt - s0 !== 1) begin errors++; $display("FAIL send_%h_command_sent got %0d want 1", b, sent_cnt - s0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL send_%h_tx_error got %0d want 0", b, err_cnt - e0); end
        checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL send_%h_error_code got %b want 00", b, error_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL send_%h_busy got %b want 0", b, busy); end
    endtask

    task automatic test_start_timeout;
        bit found;
        int k;
        found = 1'b0;
        start_send(8'h5A);
        for (int i = 0; i < 100; i++) begin
            @(negedge inclock);
            if (busy && !ps2_clock_oe && ps2_data_oe) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL start_to_wait_first got %b want 1", found); end
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge inclock);
            k++;
            if (tx_error) break;
        end
        checks++; if (k !== 200) begin errors++; $display("FAIL start_to_latency got %0d want 200", k); end
        checks++; if (error_code !== 2'b01) begin errors++; $display("FAIL start_to_error_code got %b want 01", error_code); end
        checks++; if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL start_to_oe got %b%b want 00", ps2_clock_oe, ps2_data_oe); end
        repeat (3) @(negedge inclock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_to_busy got %b want 0", busy); end
    endtask

    task automatic test_bit_timeout;
        logic [10:1] seen;
        bit ok;
        int s0, e0;
        s0 = sent_cnt;
        e0 = err_cnt;
        start_send(8'hA3);
        run_device(5, 1'b0, seen, ok);
        wait_done(s0, e0);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bit_to_tx_error got %0d want 1", err_cnt - e0); end
        checks++; if (sent_cnt - s0 !== 0) begin errors++; $display("FAIL bit_to_command_sent got %0d want 0", sent_cnt - s0); end
        checks++; if (error_code !== 2'b10) begin errors++; $display("FAIL bit_to_error_code got %b want 10", error_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bit_to_busy got %b want 0", busy); end
        checks++; if (ps2_clock_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL bit_to_oe got %b%b want 00", ps2_clock_oe, ps2_data_oe); end
    endtask

    task automatic test_no_ack;
        logic [10:1] seen;
        bit ok;
        int s0, e0;
        s0 = sent_cnt;
        e0 = err_cnt;
        start_send(8'hF4);
        run_device(11, 1'b1, seen, ok);
        wait_done(s0, e0);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL noack_tx_error got %0d want 1", err_cnt - e0); end
        checks++; if (sent_cnt - s0 !== 0) begin errors++; $display("FAIL noack_command_sent got %0d want 0", sent_cnt - s0); end
        checks++; if (error_code !== 2'b11) begin errors++; $display("FAIL noack_error_code got %b want 11", error_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noack_busy got %b want 0", busy); end
    endtask

    task automatic test_busy_ignore;
        logic [10:1] seen;
        logic [7:0]  b;
        bit ok;
        int s0, e0;
        b  = 8'h3C;
        s0 = sent_cnt;
        e0 = err_cnt;
        start_send(b);
        fork
            run_device(11, 1'b0, seen, ok);
            begin
                repeat (30) @(negedge inclock);
                send_command = 1'b1;
                command_byte = ~b;
                @(negedge inclock);
                send_command = 1'b0;
                repeat (90) @(negedge inclock);
                send_command = 1'b1;
                command_byte = 8'hC5;
                @(negedge inclock);
                send_command = 1'b0;
            end
        join
        for (int n = 1; n <= 10; n++) begin
            checks++;
            if (seen[n] !== expected_oe(b, n)) begin
                errors++;
                $display("FAIL busy_ignore_edge%0d data_oe got %b want %b", n, seen[n], expected_oe(b, n));
            end
        end
        wait_done(s0, e0);
        repeat (30) @(negedge inclock);
        checks++; if (sent_cnt - s0 !== 1) begin errors++; $display("FAIL busy_ignore_command_sent got %0d want 1", sent_cnt - s0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL busy_ignore_tx_error got %0d want 0", err_cnt - e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        logic [10:1] seen;
        bit ok;
        int s0, e0;
        // Bit 3 is 0, so the host is pulling data low right after edge 4.
        start_send(8'h07);
        run_device(4, 1'b0, seen, ok);
        checks++; if (seen[4] !== 1'b1) begin errors++; $display("FAIL reset_mid_pre_data_oe got %b want 1", seen[4]); end
        @(negedge inclock);
        resetn = 1'b0;
        #1;
        checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_mid_data_oe got %b want 0", ps2_data_oe); end
        checks++; if (ps2_clock_oe !== 1'b0) begin errors++; $display("FAIL reset_mid_clock_oe got %b want 0", ps2_clock_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", busy); end
        s0 = sent_cnt;
        e0 = err_cnt;
        @(negedge inclock);
        resetn = 1'b1;
        repeat (300) @(negedge inclock);
        checks++; if (sent_cnt !== s0) begin errors++; $display("FAIL reset_mid_command_sent got %0d want %0d", sent_cnt, s0); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL reset_mid_tx_error got %0d want %0d", err_cnt, e0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy_after got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_send(8'hED);
        test_send(8'h00);
        test_send(8'hFF);
        for (int i = 0; i < 3; i++) test_send(8'($urandom));
        test_start_timeout();
        test_bit_timeout();
        test_no_ack();
        test_send(8'($urandom));
        test_busy_ignore();
        test_reset_mid_frame();
        test_send(8'($urandom));
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL sent_and_error_together got %0d want 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
